// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: FSM encoding and controlled-counter width.
package counter_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    function automatic logic is_busy(input state_t st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Down-counting tick divider: a tick every reload+1 run cycles, frozen while run is low.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic                  run_i,
    input  logic [PRESCALE_W-1:0] reload_i,
    output logic                  tick_o
);

    localparam logic [PRESCALE_W-1:0] PS_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PS_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] r_count;
    logic                  w_zero;

    assign w_zero = (r_count == PS_ZERO);
    assign tick_o = run_i & w_zero;

    // Down-counter: load on start, reload on tick, hold when not running
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_count <= PS_ZERO;
        end else if (load_i) begin
            r_count <= reload_i;
        end else if (run_i) begin
            if (w_zero) begin
                r_count <= reload_i;
            end else begin
                r_count <= r_count - PS_ONE;
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer driving an external 4-bit counter: one-shot to a target or continuous,
// with prescaled enables, pause/hold and abort.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  pause_i,
    input  logic                  mode_i,
    input  logic [CNT_W-1:0]      target_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic [CNT_W-1:0]      counter_value_i,
    output logic                  count_enable_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wrap_o
);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_mode;
    logic [CNT_W-1:0]      r_target;
    logic [PRESCALE_W-1:0] r_prescale;

    logic                  w_start;
    logic                  w_run;
    logic                  w_tick;
    logic                  w_match;
    logic [PRESCALE_W-1:0] w_reload;

    assign w_start  = (r_state == ST_IDLE) && start_i && !stop_i;
    assign w_run    = (r_state == ST_RUN);
    assign w_match  = (counter_value_i == r_target);
    // The prescaler takes the fresh input on start and the latched copy afterwards
    assign w_reload = w_start ? prescale_i : r_prescale;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .load_i   (w_start),
        .run_i    (w_run),
        .reload_i (w_reload),
        .tick_o   (w_tick)
    );

    // FSM state register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Run configuration captured when a run starts
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_mode     <= 1'b0;
            r_target   <= {CNT_W{1'b0}};
            r_prescale <= {PRESCALE_W{1'b0}};
        end else if (w_start) begin
            r_mode     <= mode_i;
            r_target   <= target_i;
            r_prescale <= prescale_i;
        end else begin
            r_mode     <= r_mode;
            r_target   <= r_target;
            r_prescale <= r_prescale;
        end
    end

    // Next-state logic: stop beats pause, pause beats target match
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    w_next_state = ST_IDLE;
                end else if (pause_i) begin
                    w_next_state = ST_HOLD;
                end else if (!r_mode && w_match) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (stop_i) begin
                    w_next_state = ST_IDLE;
                end else if (pause_i) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; an abort masks enable and done in its cycle
    always_comb begin
        count_enable_o = 1'b0;
        if (w_run && w_tick && !stop_i && (r_mode || !w_match)) begin
            count_enable_o = 1'b1;
        end else begin
            count_enable_o = 1'b0;
        end
        wrap_o = count_enable_o && (counter_value_i == CNT_MAX);
        busy_o = is_busy(r_state);
        done_o = (r_state == ST_DONE) && !stop_i;
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer with a behavioural external counter.
module tb_counter_sequencer;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic       stop_i;
    logic       pause_i;
    logic       mode_i;
    logic [3:0] target_i;
    logic [7:0] prescale_i;
    logic [3:0] ctr;
    logic       count_enable_o;
    logic       busy_o;
    logic       done_o;
    logic       wrap_o;

    logic       preset_req;
    logic [3:0] preset_val;

    int n_cmp = 0;
    int n_mis = 0;

    counter_sequencer #(.PRESCALE_W(8)) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .pause_i         (pause_i),
        .mode_i          (mode_i),
        .target_i        (target_i),
        .prescale_i      (prescale_i),
        .counter_value_i (ctr),
        .count_enable_o  (count_enable_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .wrap_o          (wrap_o)
    );

    always #5 clock_i = ~clock_i;

    // External wrap-at-15 counter controlled by the DUT
    always @(posedge clock_i) begin
        if (preset_req) ctr <= preset_val;
        else if (count_enable_o) ctr <= ctr + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock_i);
        #1;
    endtask

    task automatic preset(input logic [3:0] v);
        preset_req = 1'b1;
        preset_val = v;
        cyc();
        preset_req = 1'b0;
    endtask

    task automatic launch(input logic m, input logic [3:0] t, input logic [7:0] p);
        mode_i = m; target_i = t; prescale_i = p; start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        #1;
    endtask

    initial begin
        int first;
        int nen;
        int waited;
        reset_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0;
        mode_i = 1'b0; target_i = 4'd0; prescale_i = 8'd0;
        preset_req = 1'b0; preset_val = 4'd0;
        preset(4'd0);
        cyc();
        chk("rst_en", count_enable_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_wrap", wrap_o, 1'b0);
        reset_i = 1'b0;
        cyc();

        // One-shot to 5, no prescale
        launch(1'b0, 4'd5, 8'd0);
        for (int i = 0; i < 5; i++) begin
            chk("os5_en", count_enable_o, 1'b1);
            chk("os5_val", ctr, i);
            chk("os5_busy", busy_o, 1'b1);
            cyc();
        end
        chk("os5_match_en", count_enable_o, 1'b0);
        chk("os5_match_done", done_o, 1'b0);
        cyc();
        chk("os5_done", done_o, 1'b1);
        start_i = 1'b1;
        #1;
        cyc();
        start_i = 1'b0;
        #1;
        chk("os5_idle_busy", busy_o, 1'b0);
        chk("os5_idle_done", done_o, 1'b0);
        cyc();
        chk("start_in_done_ignored", busy_o, 1'b0);

        // One-shot to 3 with prescale 3: enables at RUN cycles 4, 8, 12
        preset(4'd0);
        launch(1'b0, 4'd3, 8'd3);
        for (int r = 1; r <= 12; r++) begin
            chk("ps3_en", count_enable_o, (r % 4 == 0) ? 1'b1 : 1'b0);
            cyc();
        end
        chk("ps3_val", ctr, 4'd3);
        chk("ps3_pre_done", done_o, 1'b0);
        cyc();
        chk("ps3_done", done_o, 1'b1);
        cyc();
        chk("ps3_idle", busy_o, 1'b0);

        // Continuous from 14: second enable wraps
        preset(4'd14);
        launch(1'b1, 4'd0, 8'd0);
        chk("cont_wrap0", wrap_o, 1'b0);
        chk("cont_en0", count_enable_o, 1'b1);
        cyc();
        chk("cont_val15", ctr, 4'd15);
        chk("cont_wrap1", wrap_o, 1'b1);
        cyc();
        chk("cont_val0", ctr, 4'd0);
        chk("cont_wrap2", wrap_o, 1'b0);
        chk("cont_en2", count_enable_o, 1'b1);
        cyc();
        chk("cont_val1", ctr, 4'd1);
        stop_i = 1'b1;
        #1;
        chk("cont_stop_en", count_enable_o, 1'b0);
        cyc();
        stop_i = 1'b0;
        #1;
        chk("cont_stop_busy", busy_o, 1'b0);

        // One-shot to 9, prescale 2, pause for 10 cycles after two enables
        preset(4'd0);
        launch(1'b0, 4'd9, 8'd2);
        for (int c = 1; c <= 6; c++) begin
            chk("pz_en", count_enable_o, (c % 3 == 0) ? 1'b1 : 1'b0);
            cyc();
        end
        chk("pz_val2", ctr, 4'd2);
        pause_i = 1'b1;
        #1;
        for (int h = 0; h < 9; h++) begin
            cyc();
            chk("pz_hold_en", count_enable_o, 1'b0);
            chk("pz_hold_busy", busy_o, 1'b1);
        end
        cyc();
        pause_i = 1'b0;
        #1;
        chk("pz_last_hold_en", count_enable_o, 1'b0);
        cyc();
        chk("pz_resume1_en", count_enable_o, 1'b0);
        cyc();
        chk("pz_resume2_en", count_enable_o, 1'b1);
        waited = 0;
        nen = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            waited++;
            if (done_o) break;
            if (count_enable_o) nen++;
        end
        chk("pz_wait", waited, 20);
        chk("pz_enables", nen, 6);
        chk("pz_val9", ctr, 4'd9);
        chk("pz_done", done_o, 1'b1);
        cyc();
        chk("pz_idle", busy_o, 1'b0);

        // stop and pause together in RUN
        launch(1'b0, 4'd12, 8'd0);
        cyc();
        stop_i = 1'b1;
        pause_i = 1'b1;
        #1;
        chk("sp_en", count_enable_o, 1'b0);
        cyc();
        chk("sp_busy", busy_o, 1'b0);
        chk("sp_done", done_o, 1'b0);
        stop_i = 1'b0;
        pause_i = 1'b0;
        cyc();
        chk("sp_done2", done_o, 1'b0);
        chk("sp_val", ctr, 4'd10);

        // Maximum prescale: one tick per 256 RUN cycles
        preset(4'd0);
        launch(1'b1, 4'd0, 8'd255);
        first = 0;
        nen = 0;
        for (int r = 1; r <= 512; r++) begin
            if (count_enable_o) begin
                nen++;
                if (first == 0) first = r;
            end
            cyc();
        end
        chk("max_first", first, 256);
        chk("max_count", nen, 2);
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;

        // Already at target: one RUN cycle with no enable, then DONE
        preset(4'd4);
        launch(1'b0, 4'd4, 8'd0);
        chk("eq_busy", busy_o, 1'b1);
        chk("eq_en", count_enable_o, 1'b0);
        cyc();
        chk("eq_done", done_o, 1'b1);
        cyc();
        chk("eq_idle", busy_o, 1'b0);

        // Reset mid-prescale beats a simultaneous start
        launch(1'b0, 4'd15, 8'd5);
        cyc();
        cyc();
        reset_i = 1'b1;
        start_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_en", count_enable_o, 1'b0);
        chk("mid_rst_done", done_o, 1'b0);
        chk("mid_rst_wrap", wrap_o, 1'b0);
        cyc();
        cyc();
        chk("post_rst_done", done_o, 1'b0);
        chk("post_rst_busy", busy_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
